// File: rtl/maze_pkg.sv
// Shared types and constants for the travel plan sequencer: actions, FSM states,
// heading arithmetic and timer lengths.
package maze_pkg;

  localparam int HDNG_W   = 13;
  localparam int SUM_W    = HDNG_W + 1;
  localparam int PLAN_W   = 16;
  localparam int TMR_W    = 21;
  localparam int HW_SCALE = 16;

  typedef logic signed [HDNG_W-1:0] hdng_t;
  typedef logic signed [SUM_W-1:0]  hsum_t;
  typedef logic [TMR_W-1:0]         tmr_t;

  localparam hsum_t HSUM_MAX  = hsum_t'(1799);
  localparam hsum_t HSUM_MIN  = hsum_t'(-1800);
  localparam hsum_t HSUM_WRAP = hsum_t'(3600);

  typedef enum logic [1:0] {
    ACT_STOP   = 2'b00,
    ACT_VEER_R = 2'b01,
    ACT_VEER_L = 2'b10,
    ACT_TURN   = 2'b11
  } action_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_FOLLOW,
    ST_GAP,
    ST_VEER,
    ST_TURN1,
    ST_TURN2
  } state_t;

  // Simulation timer lengths; hardware builds stretch each by HW_SCALE.
  function automatic int gap_deb_cyc(input int fast);
    return (fast != 0) ? 1024 : 1024 * HW_SCALE;
  endfunction

  function automatic int veer_hold_cyc(input int fast);
    return (fast != 0) ? 65536 : 65536 * HW_SCALE;
  endfunction

  function automatic int turn_step_cyc(input int fast);
    return (fast != 0) ? 131072 : 131072 * HW_SCALE;
  endfunction

endpackage

// File: rtl/hdng_wrap_add.sv
// Signed heading add wrapped modulo 3600 into [-1800,1799] (0.1 degree units).
module hdng_wrap_add
  import maze_pkg::*;
(
  input  logic signed [HDNG_W-1:0] hdng,
  input  logic signed [HDNG_W-1:0] delta,
  output logic signed [HDNG_W-1:0] sum
);

  hsum_t raw;

  always_comb begin
    raw = hsum_t'(hdng) + hsum_t'(delta);
    sum = hdng_t'(raw);
    if (raw > HSUM_MAX) begin
      sum = hdng_t'(raw - HSUM_WRAP);
    end else if (raw < HSUM_MIN) begin
      sum = hdng_t'(raw + HSUM_WRAP);
    end
  end

endmodule

// File: rtl/travel_plan_sequencer.sv
// Runs the eight-action travel plan: one action per debounced line gap, steering
// through the desired heading; a bump aborts the plan and raises the buzzer.
module travel_plan_sequencer
  import maze_pkg::*;
#(
  parameter int FAST_SIM  = 1,
  parameter int VEER_ANG  = 350,
  parameter int TURN_ANG  = 900,
  parameter int GAP_DEB   = gap_deb_cyc(FAST_SIM),
  parameter int VEER_HOLD = veer_hold_cyc(FAST_SIM),
  parameter int TURN_STEP = turn_step_cyc(FAST_SIM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PLAN_W-1:0]        cmd,
  input  logic                     cmd_rdy,
  output logic                     clr_cmd_rdy,
  input  logic                     line_present,
  input  logic                     bump,
  output logic                     go,
  output logic signed [HDNG_W-1:0] dsrd_hdng,
  output logic                     hdng_vld,
  output logic                     buzz_en,
  output logic                     plan_done
);

  // Timers count N-1 down to 0 so a phase lasts exactly N cycles.
  localparam tmr_t GAP_LD  = tmr_t'(GAP_DEB - 1);
  localparam tmr_t VEER_LD = tmr_t'(VEER_HOLD - 1);
  localparam tmr_t TURN_LD = tmr_t'(TURN_STEP - 1);

  state_t            state;
  logic [PLAN_W-1:0] plan;
  tmr_t              tmr;
  action_t           act;
  hdng_t             delta;
  hdng_t             hdng_next;

  assign act = action_t'(plan[1:0]);

  always_comb begin
    delta = hdng_t'(TURN_ANG);
    if (state == ST_GAP && act == ACT_VEER_R) begin
      delta = hdng_t'(VEER_ANG);
    end else if (state == ST_GAP && act == ACT_VEER_L) begin
      delta = hdng_t'(-VEER_ANG);
    end
  end

  hdng_wrap_add u_wrap (
    .hdng  (dsrd_hdng),
    .delta (delta),
    .sum   (hdng_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      plan        <= '0;
      tmr         <= '0;
      go          <= 1'b0;
      dsrd_hdng   <= '0;
      hdng_vld    <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      buzz_en     <= 1'b0;
      plan_done   <= 1'b1;
    end else begin
      hdng_vld    <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      if (state != ST_IDLE && bump) begin
        go        <= 1'b0;
        buzz_en   <= 1'b1;
        plan_done <= 1'b1;
        plan      <= '0;
        tmr       <= '0;
        state     <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd_rdy) begin
              plan        <= cmd;
              clr_cmd_rdy <= 1'b1;
              state       <= ST_ACCEPT;
            end
          end
          ST_ACCEPT: begin
            go        <= 1'b1;
            plan_done <= 1'b0;
            buzz_en   <= 1'b0;
            tmr       <= GAP_LD;
            state     <= ST_FOLLOW;
          end
          ST_FOLLOW: begin
            if (line_present) begin
              tmr <= GAP_LD;
            end else if (tmr == '0) begin
              state <= ST_GAP;
            end else begin
              tmr <= tmr - tmr_t'(1);
            end
          end
          ST_GAP: begin
            plan <= {2'b00, plan[PLAN_W-1:2]};
            case (act)
              ACT_STOP: begin
                go        <= 1'b0;
                plan_done <= 1'b1;
                tmr       <= '0;
                state     <= ST_IDLE;
              end
              ACT_TURN: begin
                dsrd_hdng <= hdng_next;
                hdng_vld  <= 1'b1;
                tmr       <= TURN_LD;
                state     <= ST_TURN1;
              end
              default: begin
                dsrd_hdng <= hdng_next;
                hdng_vld  <= 1'b1;
                tmr       <= VEER_LD;
                state     <= ST_VEER;
              end
            endcase
          end
          ST_TURN1: begin
            if (tmr != '0) begin
              tmr <= tmr - tmr_t'(1);
            end else begin
              dsrd_hdng <= hdng_next;
              hdng_vld  <= 1'b1;
              tmr       <= TURN_LD;
              state     <= ST_TURN2;
            end
          end
          ST_VEER, ST_TURN2: begin
            // Leave the maneuver only once the hold has run out and the line is back.
            if (tmr != '0) begin
              tmr <= tmr - tmr_t'(1);
            end else if (line_present) begin
              tmr   <= GAP_LD;
              state <= ST_FOLLOW;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_travel_plan_sequencer.sv
// Directed-random bench: plans and line patterns drive the sequencer while a
// heading/timing model derived from the plan rules predicts every response.
module tb_travel_plan_sequencer;

  localparam int TB_GAP  = 16;
  localparam int TB_VEER = 40;
  localparam int TB_TURN = 60;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        cmd;
  logic               cmd_rdy;
  logic               clr_cmd_rdy;
  logic               line_present;
  logic               bump;
  logic               go;
  logic signed [12:0] dsrd_hdng;
  logic               hdng_vld;
  logic               buzz_en;
  logic               plan_done;

  int n_chk   = 0;
  int n_fail  = 0;
  int vld_cnt = 0;
  int clr_cnt = 0;
  int h       = 0;

  always #5 clk = ~clk;

  travel_plan_sequencer #(
    .FAST_SIM  (1),
    .VEER_ANG  (350),
    .TURN_ANG  (900),
    .GAP_DEB   (TB_GAP),
    .VEER_HOLD (TB_VEER),
    .TURN_STEP (TB_TURN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .line_present (line_present),
    .bump         (bump),
    .go           (go),
    .dsrd_hdng    (dsrd_hdng),
    .hdng_vld     (hdng_vld),
    .buzz_en      (buzz_en),
    .plan_done    (plan_done)
  );

  function automatic int wrap(input int v);
    int m;
    m = (v + 1800) % 3600;
    if (m < 0) m += 3600;
    return m - 1800;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; the command source drops cmd_rdy as soon as it sees clr_cmd_rdy.
  task automatic step1();
    @(posedge clk);
    #1;
    if (hdng_vld) vld_cnt++;
    if (clr_cmd_rdy) begin
      clr_cnt++;
      cmd_rdy = 1'b0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) step1();
  endtask

  task automatic send(input logic [15:0] c);
    int k;
    int c0;
    cmd = c;
    cmd_rdy = 1'b1;
    c0 = clr_cnt;
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      step1();
      if (go) begin
        k = i;
        break;
      end
    end
    chk("accept_latency", k, 2);
    chk("clr_once", clr_cnt - c0, 1);
    chk("accept_plan_done", plan_done, 0);
    chk("accept_buzz", buzz_en, 0);
  endtask

  // Short dropouts below the debounce length must not be seen as gaps.
  task automatic follow_noise(input int n);
    int v0;
    v0 = vld_cnt;
    for (int i = 0; i < n; i++) begin
      line_present = 1'b1;
      step($urandom_range(8, 2));
      line_present = 1'b0;
      step($urandom_range(TB_GAP - 1, 1));
    end
    line_present = 1'b1;
    step(2);
    chk("noise_no_vld", vld_cnt - v0, 0);
    chk("noise_go", go, 1);
    chk("noise_hdng", $signed(dsrd_hdng), h);
  endtask

  task automatic run_gap(input int a);
    int k;
    int v0;
    line_present = 1'b0;
    v0 = vld_cnt;
    k = 0;
    for (int i = 1; i <= TB_GAP + 4; i++) begin
      step1();
      if ((a == 0 && !go) || (a != 0 && hdng_vld)) begin
        k = i;
        break;
      end
    end
    chk("gap_latency", k, TB_GAP + 1);
    if (a == 0) begin
      chk("stop_done", plan_done, 1);
      chk("stop_hdng", $signed(dsrd_hdng), h);
      chk("stop_no_vld", vld_cnt - v0, 0);
      line_present = 1'b1;
      step1();
    end else begin
      h = wrap(h + ((a == 1) ? 350 : (a == 2) ? -350 : 900));
      chk("gap_hdng", $signed(dsrd_hdng), h);
      chk("gap_one_vld", vld_cnt - v0, 1);
      if (a == 3) begin
        k = 0;
        for (int i = 1; i <= TB_TURN + 4; i++) begin
          step1();
          if (hdng_vld) begin
            k = i;
            break;
          end
        end
        chk("turn_step", k, TB_TURN);
        h = wrap(h + 900);
        chk("turn2_hdng", $signed(dsrd_hdng), h);
      end
      v0 = vld_cnt;
      step(((a == 3) ? TB_TURN : TB_VEER) + TB_GAP + 10);
      chk("hold_no_vld", vld_cnt - v0, 0);
      chk("hold_go", go, 1);
      line_present = 1'b1;
      step(5);
    end
  endtask

  task automatic run_plan(input int c);
    for (int i = 0; i < 9; i++) begin
      automatic int a = (i < 8) ? ((c >> (2 * i)) & 3) : 0;
      follow_noise(2);
      run_gap(a);
      if (a == 0) break;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    h = 0;
    chk("rst_hdng", $signed(dsrd_hdng), 0);
  endtask

  initial begin
    int k;
    int c0;
    logic [31:0] r;

    rst = 1'b1;
    cmd = '0;
    cmd_rdy = 1'b0;
    line_present = 1'b1;
    bump = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_go", go, 0);
    chk("rst_hdng0", $signed(dsrd_hdng), 0);
    chk("rst_vld", hdng_vld, 0);
    chk("rst_clr", clr_cmd_rdy, 0);
    chk("rst_buzz", buzz_en, 0);
    chk("rst_plan_done", plan_done, 1);
    rst = 1'b0;

    bump = 1'b1;
    step(4);
    chk("idle_bump_buzz", buzz_en, 0);
    chk("idle_bump_done", plan_done, 1);
    bump = 1'b0;

    send(16'h0001);
    run_plan(16'h0001);
    chk("veer_r_350", $signed(dsrd_hdng), 350);

    pulse_reset();
    send(16'h0002);
    run_plan(16'h0002);
    chk("veer_l_m350", $signed(dsrd_hdng), -350);

    pulse_reset();
    send(16'h0003);
    run_plan(16'h0003);
    chk("turn_wrap", $signed(dsrd_hdng), -1800);

    send(16'h5555);
    run_plan(16'h5555);
    chk("exhaust_hdng", $signed(dsrd_hdng), 1000);

    send(16'h0015);
    run_plan(16'h0015);
    chk("wrap_1700_veer", $signed(dsrd_hdng), -1550);

    // Command arriving mid-plan waits for the plan to end.
    send(16'h0001);
    follow_noise(1);
    cmd = 16'h0002;
    cmd_rdy = 1'b1;
    c0 = clr_cnt;
    follow_noise(3);
    chk("busy_no_clr", clr_cnt - c0, 0);
    run_gap(1);
    follow_noise(2);
    chk("busy_no_clr2", clr_cnt - c0, 0);
    run_gap(0);
    chk("clr_after_plan", clr_cnt - c0, 1);
    step1();
    chk("pending_go", go, 1);
    run_plan(16'h0002);

    // Bump during VEER together with a fresh command.
    send(16'h0001);
    follow_noise(2);
    line_present = 1'b0;
    k = 0;
    for (int i = 1; i <= TB_GAP + 4; i++) begin
      step1();
      if (hdng_vld) begin
        k = i;
        break;
      end
    end
    chk("bump_gap_latency", k, TB_GAP + 1);
    h = wrap(h + 350);
    step(10);
    bump = 1'b1;
    line_present = 1'b1;
    cmd = 16'h0005;
    cmd_rdy = 1'b1;
    c0 = clr_cnt;
    step1();
    bump = 1'b0;
    chk("bump_go", go, 0);
    chk("bump_buzz", buzz_en, 1);
    chk("bump_done", plan_done, 1);
    chk("bump_no_clr", clr_cnt - c0, 0);
    chk("bump_hdng", $signed(dsrd_hdng), h);
    step1();
    chk("bump_cmd_accept", clr_cnt - c0, 1);
    chk("buzz_hold", buzz_en, 1);
    step1();
    chk("buzz_clear", buzz_en, 0);
    chk("bump_restart", go, 1);
    run_plan(16'h0005);

    // Asynchronous reset in the middle of a turn.
    send(16'h0003);
    follow_noise(1);
    line_present = 1'b0;
    k = 0;
    for (int i = 1; i <= TB_GAP + 4; i++) begin
      step1();
      if (hdng_vld) begin
        k = i;
        break;
      end
    end
    chk("turn1_gap_latency", k, TB_GAP + 1);
    h = wrap(h + 900);
    chk("turn1_hdng", $signed(dsrd_hdng), h);
    step(5);
    rst = 1'b1;
    #1;
    chk("arst_go", go, 0);
    chk("arst_hdng", $signed(dsrd_hdng), 0);
    chk("arst_vld", hdng_vld, 0);
    chk("arst_clr", clr_cmd_rdy, 0);
    chk("arst_buzz", buzz_en, 0);
    chk("arst_done", plan_done, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    line_present = 1'b1;
    h = 0;
    step(2);
    chk("post_rst_idle", plan_done, 1);

    repeat (3) begin
      r = $urandom;
      send(r[15:0]);
      run_plan(int'(r[15:0]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
